// File: rtl/tsc_pkg.sv
// Shared types, default parameters and helpers for the transient sample capture controller.
package tsc_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_BUF_DEPTH    = 16;
    localparam int DEF_POST_SAMPLES = 8;
    localparam int DEF_SAMPLE_DIV   = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_BUF_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_POST = 3'd2,
        ST_DONE = 3'd3,
        ST_SEND = 3'd4
    } state_e;

endpackage

// File: rtl/tsc_ring_buf.sv
// Sample ring buffer: wrapping write pointer, registered read port that clears on reset.
module tsc_ring_buf
    import tsc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    localparam int AW       = ptr_width(BUF_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [AW-1:0]     wr_ptr_o,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [DATA_W-1:0] rd_data_q;

    // Depth is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
        end
    end

    assign wr_ptr_o  = wr_ptr_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tsc.sv
// Transient sample capture: paces ADC requests, freezes a pre/post-trigger window
// in the ring buffer and streams it out serially, oldest sample first, MSB first.
module tsc
    import tsc_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
    parameter int POST_SAMPLES = DEF_POST_SAMPLES,
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] trig_lvl,
    input  logic              sbf,
    output logic              adc_req,
    input  logic              adc_rdy,
    input  logic [DATA_W-1:0] adc_dat,
    output logic              trd,
    output logic              cd,
    output logic              sd,
    output logic              sd_valid
);

    localparam int AW = ptr_width(BUF_DEPTH);
    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int PW = $clog2(POST_SAMPLES + 1);
    localparam int BW = ptr_width(DATA_W);

    localparam logic [SW-1:0] SLOT_CAP  = SW'(2);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] POST_LOAD = PW'(POST_SAMPLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [AW-1:0] WORD_LAST = AW'(BUF_DEPTH - 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [PW-1:0]     post_q, post_d;
    logic              trd_q, trd_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     word_q, word_d;
    logic [BW-1:0]     bit_q, bit_d;

    logic              sampling;
    logic              capture;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     wr_ptr;
    logic [DATA_W-1:0] rd_word;

    assign sampling = (state_q == ST_RUN) || (state_q == ST_POST);
    assign capture  = sampling && (slot_q == SLOT_CAP) && adc_rdy;

    tsc_ring_buf #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (capture),
        .wr_data_i (adc_dat),
        .wr_ptr_o  (wr_ptr),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_word)
    );

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        post_d   = post_q;
        trd_d    = trd_q;
        rd_ptr_d = rd_ptr_q;
        word_d   = word_q;
        bit_d    = bit_q;
        rd_en    = 1'b0;
        rd_addr  = rd_ptr_q;

        // Slot counter stalls at the capture slot until the ADC reports valid data.
        if (sampling && !((slot_q == SLOT_CAP) && !adc_rdy)) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    slot_d  = '0;
                end
            end
            ST_RUN: begin
                if (capture && (adc_dat > trig_lvl)) begin
                    trd_d   = 1'b1;
                    post_d  = POST_LOAD;
                    state_d = (POST_SAMPLES == 1) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (capture) begin
                    post_d = post_q - PW'(1);
                    if (post_q == PW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Prefetch the oldest entry so the first bit is on sd the very next cycle.
                if (sbf) begin
                    state_d  = ST_SEND;
                    rd_en    = 1'b1;
                    rd_addr  = wr_ptr;
                    rd_ptr_d = wr_ptr + AW'(1);
                    word_d   = '0;
                    bit_d    = '0;
                end
            end
            ST_SEND: begin
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (word_q == WORD_LAST) begin
                        state_d = ST_IDLE;
                        trd_d   = 1'b0;
                    end else begin
                        rd_en    = 1'b1;
                        word_d   = word_q + AW'(1);
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            post_q   <= '0;
            trd_q    <= 1'b0;
            rd_ptr_q <= '0;
            word_q   <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            post_q   <= post_d;
            trd_q    <= trd_d;
            rd_ptr_q <= rd_ptr_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
        end
    end

    assign adc_req  = sampling && (slot_q == '0);
    assign trd      = trd_q;
    assign cd       = (state_q == ST_DONE);
    assign sd_valid = (state_q == ST_SEND);
    assign sd       = sd_valid & rd_word[BIT_LAST - bit_q];

endmodule

// File: tb/tb_tsc.sv
// Scoreboard bench for tsc: ADC model, expected bytes queued at sbf, compared as bits arrive.
module tb_tsc;
    import tsc_pkg::*;

    localparam int DW    = DEF_DATA_W;
    localparam int NBITS = (1 << DEF_PTR_W) * DEF_DATA_W;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic [DW-1:0] trig_lvl = '0;
    logic          sbf      = 1'b0;
    logic          adc_req;
    logic          adc_rdy  = 1'b1;
    logic [DW-1:0] adc_dat;
    logic          trd, cd, sd, sd_valid;

    int n_cmp   = 0;
    int n_bad   = 0;
    int req_cnt = 0;
    int bursts  = 0;
    int last_len = 0;
    int idle_hi = 0;
    int adc_idx;

    logic [7:0] sb [$];

    logic [7:0] tbl [32] = '{
        8'h8B, 8'h8C, 8'h99, 8'h9B, 8'h93, 8'h82, 8'h97, 8'h90,
        8'h9F, 8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h91, 8'h8C,
        8'h8B, 8'h93, 8'h9A, 8'h81, 8'h88, 8'h9E, 8'h95, 8'h86,
        8'h8F, 8'h94, 8'h83, 8'h9D, 8'h8E, 8'h97, 8'h90, 8'h99
    };
    logic [7:0] exp_a [16] = '{
        8'h8C, 8'h99, 8'h9B, 8'h93, 8'h82, 8'h97, 8'h90, 8'h9F,
        8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h91, 8'h8C, 8'h8B
    };
    logic [7:0] exp_b [16] = '{
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h8B, 8'h8C, 8'h99, 8'h9B, 8'h93, 8'h82, 8'h97, 8'h90
    };

    tsc dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .trig_lvl (trig_lvl),
        .sbf      (sbf),
        .adc_req  (adc_req),
        .adc_rdy  (adc_rdy),
        .adc_dat  (adc_dat),
        .trd      (trd),
        .cd       (cd),
        .sd       (sd),
        .sd_valid (sd_valid)
    );

    always #5 clk = ~clk;

    // ADC model: presents the next table sample the cycle after each request.
    always @(posedge clk) begin
        if (rst) begin
            adc_idx <= 0;
            adc_dat <= '0;
        end else if (adc_req) begin
            adc_dat <= tbl[adc_idx];
            adc_idx <= (adc_idx + 1) % 32;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (adc_req) req_cnt++;
        end
    end

    // Serial collector: assembles bytes MSB first and pops the scoreboard.
    initial begin
        logic [7:0] acc;
        logic [7:0] exp;
        int nb, cur_len;
        bit in_burst;
        acc = '0; nb = 0; cur_len = 0; in_burst = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc = '0; nb = 0; in_burst = 0;
                continue;
            end
            if (sd_valid) begin
                if (!in_burst) begin
                    in_burst = 1;
                    bursts++;
                    cur_len = 0;
                end
                cur_len++;
                acc = {acc[6:0], sd};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (sb.size() == 0) begin
                        check("sb_nonempty", sb.size(), 1);
                    end else begin
                        exp = sb.pop_front();
                        check("byte", acc, exp);
                    end
                end
            end else begin
                if (in_burst) begin
                    in_burst = 0;
                    last_len = cur_len;
                end
                if (sd) idle_hi++;
            end
        end
    end

    task automatic wait_for(input int sel, input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((sel == 0 && cd) || (sel == 1 && trd) || (sel == 2 && !sd_valid) ||
                (sel == 3 && adc_req)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_outs", {adc_req, trd, cd, sd, sd_valid}, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic start_capture(input logic [7:0] thr);
        @(negedge clk);
        trig_lvl = thr;
        req_cnt  = 0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input bit use_b);
        for (int i = 0; i < 16; i++) begin
            sb.push_back(use_b ? exp_b[i] : exp_a[i]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int b0, n, g;

        do_reset();

        // Threshold 0xC0 with the first capture slot stalled for 5 cycles.
        start_capture(8'hC0);
        check("first_req", adc_req, 1);
        wait_for(3, 20, ok);
        check("req_seen", ok, 1);
        @(posedge clk);
        #1 adc_rdy = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (adc_req) n++;
            @(posedge clk);
        end
        #1 adc_rdy = 1'b1;
        check("stall_no_req", n, 0);
        g = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g++;
            if (adc_req) break;
        end
        check("stall_req_gap", g, 3);

        wait_for(1, 200, ok);
        check("a_trd_seen", ok, 1);
        check("a_trig_sample", req_cnt, 10);
        start = 1'b1;
        sbf   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; sbf = 1'b0;
        wait_for(0, 200, ok);
        check("a_cd_seen", ok, 1);
        check("a_captures", req_cnt, 17);
        check("a_trd_hold", trd, 1);
        check("a_pre_valid", sd_valid, 0);

        push_exp(0);
        b0  = bursts;
        sbf = 1'b1;
        @(posedge clk);
        #1 sbf = 1'b0;
        check("a_first_valid", sd_valid, 1);
        check("a_cd_fall", cd, 0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        sbf   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; sbf = 1'b0;
        wait_for(2, NBITS + 10, ok);
        check("a_burst_end", ok, 1);
        check("a_trd_fall", trd, 0);
        @(posedge clk);
        #1;
        check("a_burst_len", last_len, NBITS);
        check("a_burst_cnt", bursts - b0, 1);
        check("a_sb_drained", sb.size(), 0);
        req_cnt = 0;
        repeat (12) @(negedge clk);
        check("a_idle_no_req", req_cnt, 0);
        check("a_idle_cd", cd, 0);

        // Threshold 0xFF: free-running requests, no trigger, sbf ignored.
        do_reset();
        start_capture(8'hFF);
        repeat (40) @(negedge clk);
        check("c_req_count", req_cnt, 10);
        check("c_cd", cd, 0);
        check("c_trd", trd, 0);
        b0  = bursts;
        sbf = 1'b1;
        @(posedge clk);
        #1 sbf = 1'b0;
        repeat (10) @(negedge clk);
        check("c_sbf_ignored", bursts - b0, 0);
        check("c_no_valid", sd_valid, 0);

        // Reset in the middle of a send.
        do_reset();
        start_capture(8'hC0);
        wait_for(0, 300, ok);
        check("d_cd_seen", ok, 1);
        check("d_captures", req_cnt, 17);
        push_exp(0);
        sbf = 1'b1;
        @(posedge clk);
        #1 sbf = 1'b0;
        repeat (20) @(posedge clk);
        do_reset();
        req_cnt = 0;
        repeat (8) @(negedge clk);
        check("d_idle_no_req", req_cnt, 0);
        check("d_idle_outs", {trd, cd, sd_valid}, 0);

        // Threshold 0x80 on a cleared buffer, sbf held high through the whole send.
        start_capture(8'h80);
        wait_for(1, 50, ok);
        check("b_trd_seen", ok, 1);
        check("b_trig_sample", req_cnt, 1);
        wait_for(0, 100, ok);
        check("b_cd_seen", ok, 1);
        check("b_captures", req_cnt, 8);
        push_exp(1);
        b0  = bursts;
        sbf = 1'b1;
        @(posedge clk);
        #1;
        check("b_first_valid", sd_valid, 1);
        wait_for(2, NBITS + 10, ok);
        check("b_burst_end", ok, 1);
        repeat (20) @(negedge clk);
        check("b_held_bursts", bursts - b0, 1);
        check("b_burst_len", last_len, NBITS);
        check("b_trd_low", trd, 0);
        sbf = 1'b0;
        check("b_sb_drained", sb.size(), 0);
        check("sd_idle_zero", idle_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
